gbt_link_watchdog: RTL



---
 rtl/gbt_wdg_pkg.sv | 38 +++
 rtl/gbt_wdg_channel.sv | 150 +++++++++++++++
 rtl/gbt_link_watchdog.sv | 107 ++++++++++
 3 files changed

// File: rtl/gbt_wdg_pkg.sv
// Shared types and helpers for the GBT link watchdog.
//   clk_rs_t     : clock/reset bundle (clk, synchronous active-high reset)
//   wdg_state_t  : per-channel watchdog FSM state
//   wdg_status_t : per-channel registered outputs handed to the top level
//   cnt_w()      : bit width for a counter running 0..n-1
package gbt_wdg_pkg;

    // Channels always carry a wide retry count internally. The top keeps
    // the low g_retry_w bits, so g_retry_w must not exceed this.
    localparam int WDG_RETRY_W_MAX = 32;

    typedef struct packed {
        logic clk;
        logic reset;
    } clk_rs_t;

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_WAIT_READY,
        ST_PULSE,
        ST_LINKED,
        ST_LOS,
        ST_FAILED
    } wdg_state_t;

    typedef struct packed {
        logic                       rst;
        logic                       linked;
        logic                       failed;
        logic [WDG_RETRY_W_MAX-1:0] retry_cnt;
    } wdg_status_t;

    // Width of a counter that holds 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gbt_wdg_channel.sv
// One link watchdog channel: FSM plus timeout, pulse and retry counters.
//   clk, reset    : system clock, synchronous active-high reset
//   tick_i        : shared timeout tick (one cycle wide)
//   ready_s_i     : synchronised link ready
//   los_s_i       : synchronised loss of signal
//   enable_i      : channel enable (level)
//   force_i       : request for an immediate reset pulse
//   status_o      : registered rst / linked / failed / retry count
module gbt_wdg_channel
    import gbt_wdg_pkg::*;
#(
    parameter int g_timeout_ticks = 2048,
    parameter int g_pulse_cycles  = 16,
    parameter int g_max_retries   = 7,
    parameter int g_retry_w       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_i,
    input  logic        ready_s_i,
    input  logic        los_s_i,
    input  logic        enable_i,
    input  logic        force_i,
    output wdg_status_t status_o
);

    localparam int TO_W = cnt_w(g_timeout_ticks);
    localparam int PC_W = cnt_w(g_pulse_cycles);

    localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(g_timeout_ticks - 1);
    localparam logic [PC_W-1:0]      PC_LAST   = PC_W'(g_pulse_cycles - 1);
    localparam logic [g_retry_w-1:0] RETRY_SAT = '1;
    localparam logic [31:0]          RETRY_LIM = 32'(g_max_retries);

    wdg_state_t           state_q,   state_d;
    logic [TO_W-1:0]      timeout_q, timeout_d;
    logic [PC_W-1:0]      pulse_q,   pulse_d;
    logic [g_retry_w-1:0] retry_q,   retry_d;
    logic                 rst_q,     rst_d;
    logic                 linked_q,  linked_d;
    logic                 failed_q,  failed_d;

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        pulse_d   = pulse_q;
        retry_d   = retry_q;

        if (!enable_i) begin
            state_d   = ST_DISABLED;
            timeout_d = '0;
            pulse_d   = '0;
            retry_d   = '0;
        end else if (los_s_i) begin
            state_d = ST_LOS;
        end else if (force_i) begin
            // Also restarts a pulse already in progress.
            state_d = ST_PULSE;
            pulse_d = '0;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d   = ST_WAIT_READY;
                    timeout_d = '0;
                end
                ST_WAIT_READY: begin
                    if (ready_s_i) begin
                        state_d = ST_LINKED;
                        retry_d = '0;
                    end else if (tick_i) begin
                        if (timeout_q == TO_LAST) begin
                            timeout_d = '0;
                            if ((g_max_retries != 0) && (32'(retry_q) == RETRY_LIM)) begin
                                state_d = ST_FAILED;
                            end else begin
                                state_d = ST_PULSE;
                                pulse_d = '0;
                                if (retry_q != RETRY_SAT) begin
                                    retry_d = retry_q + 1'b1;
                                end
                            end
                        end else begin
                            timeout_d = timeout_q + 1'b1;
                        end
                    end
                end
                ST_PULSE: begin
                    if (pulse_q == PC_LAST) begin
                        state_d   = ST_WAIT_READY;
                        timeout_d = '0;
                    end else begin
                        pulse_d = pulse_q + 1'b1;
                    end
                end
                ST_LINKED: begin
                    if (!ready_s_i) begin
                        state_d   = ST_WAIT_READY;
                        timeout_d = '0;
                    end
                end
                ST_LOS: begin
                    // Reached only once los_s has dropped.
                    state_d   = ST_WAIT_READY;
                    timeout_d = '0;
                end
                ST_FAILED: begin
                    if (ready_s_i) begin
                        state_d = ST_LINKED;
                        retry_d = '0;
                    end
                end
                default: begin
                    state_d = ST_DISABLED;
                end
            endcase
        end

        // Outputs are decoded from the next state so they appear on the same
        // edge the state register takes the transition.
        rst_d    = (state_d == ST_PULSE) || (state_d == ST_LOS);
        linked_d = (state_d == ST_LINKED);
        failed_d = (state_d == ST_FAILED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_DISABLED;
            timeout_q <= '0;
            pulse_q   <= '0;
            retry_q   <= '0;
            rst_q     <= 1'b0;
            linked_q  <= 1'b0;
            failed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
            pulse_q   <= pulse_d;
            retry_q   <= retry_d;
            rst_q     <= rst_d;
            linked_q  <= linked_d;
            failed_q  <= failed_d;
        end
    end

    assign status_o = '{rst:       rst_q,
                        linked:    linked_q,
                        failed:    failed_q,
                        retry_cnt: WDG_RETRY_W_MAX'(retry_q)};

endmodule

// File: rtl/gbt_link_watchdog.sv
// Multi-channel link-loss watchdog and reset sequencer for GBT/MGT links.
//   ClkRs_ix      : clock and synchronous active-high reset
//   enable_i      : per-channel watchdog enable (level)
//   ready_i       : per-channel link ready, asynchronous
//   los_i         : per-channel loss of signal, asynchronous
//   force_reset_i : per-channel request for an immediate reset pulse
//   rst_o         : per-channel transceiver reset
//   failed_o      : per-channel retries exhausted
//   linked_o      : per-channel link up
//   retry_cnt_o   : per-channel pulses issued since last link-up
//   tick_o        : shared timeout tick
module gbt_link_watchdog
    import gbt_wdg_pkg::*;
#(
    parameter int g_channels      = 4,
    parameter int g_tick_div      = 120000,
    parameter int g_timeout_ticks = 2048,
    parameter int g_pulse_cycles  = 16,
    parameter int g_max_retries   = 7,
    parameter int g_retry_w       = 8
) (
    input  clk_rs_t                              ClkRs_ix,
    input  logic [g_channels-1:0]                enable_i,
    input  logic [g_channels-1:0]                ready_i,
    input  logic [g_channels-1:0]                los_i,
    input  logic [g_channels-1:0]                force_reset_i,
    output logic [g_channels-1:0]                rst_o,
    output logic [g_channels-1:0]                failed_o,
    output logic [g_channels-1:0]                linked_o,
    output logic [g_channels-1:0][g_retry_w-1:0] retry_cnt_o,
    output logic                                 tick_o
);

    localparam int              TICK_W    = cnt_w(g_tick_div);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(g_tick_div - 1);

    logic clk;
    logic reset;
    assign clk   = ClkRs_ix.clk;
    assign reset = ClkRs_ix.reset;

    logic [g_channels-1:0] ready_meta_q, ready_meta_d;
    logic [g_channels-1:0] ready_s_q,    ready_s_d;
    logic [g_channels-1:0] los_meta_q,   los_meta_d;
    logic [g_channels-1:0] los_s_q,      los_s_d;
    logic [TICK_W-1:0]     tick_cnt_q,   tick_cnt_d;
    logic                  tick;

    always_comb begin
        ready_meta_d = ready_i;
        ready_s_d    = ready_meta_q;
        los_meta_d   = los_i;
        los_s_d      = los_meta_q;
        tick         = (tick_cnt_q == TICK_LAST);
        tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_meta_q <= '0;
            ready_s_q    <= '0;
            los_meta_q   <= '0;
            los_s_q      <= '0;
            tick_cnt_q   <= '0;
        end else begin
            ready_meta_q <= ready_meta_d;
            ready_s_q    <= ready_s_d;
            los_meta_q   <= los_meta_d;
            los_s_q      <= los_s_d;
            tick_cnt_q   <= tick_cnt_d;
        end
    end

    assign tick_o = tick;

    wdg_status_t status [g_channels];

    for (genvar i = 0; i < g_channels; i++) begin : g_ch
        gbt_wdg_channel #(
            .g_timeout_ticks (g_timeout_ticks),
            .g_pulse_cycles  (g_pulse_cycles),
            .g_max_retries   (g_max_retries),
            .g_retry_w       (g_retry_w)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .tick_i    (tick),
            .ready_s_i (ready_s_q[i]),
            .los_s_i   (los_s_q[i]),
            .enable_i  (enable_i[i]),
            .force_i   (force_reset_i[i]),
            .status_o  (status[i])
        );

        assign rst_o[i]       = status[i].rst;
        assign linked_o[i]    = status[i].linked;
        assign failed_o[i]    = status[i].failed;
        assign retry_cnt_o[i] = status[i].retry_cnt[g_retry_w-1:0];

        // Upper bits are zero-extension from the channel and carry nothing.
        if (g_retry_w < WDG_RETRY_W_MAX) begin : g_hi
            logic unused_retry_hi;
            assign unused_retry_hi = |status[i].retry_cnt[WDG_RETRY_W_MAX-1:g_retry_w];
        end
    end

endmodule
